// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline: load-use bubbles,
// taken-branch flushes and dmem wait-state freezes, with stall statistics.
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IF_ID_IR,
  input  logic [31:0]      ID_EX_IR,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  typedef enum logic [0:0] {RUN = 1'b0, LU_STALL = 1'b1} state_e;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [1:0]  LU_LAST   = 2'(LU_BUBBLES);
  localparam logic [15:0] TMO       = 16'(MEM_TIMEOUT);

  function automatic logic rs1_used(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         bub_cnt_q, bub_cnt_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic [6:0]         ifid_op_s, idex_op_s;
  logic [4:0]         ifid_rs1_s, ifid_rs2_s, idex_rd_s;
  logic               lu_haz_s, mem_wait_s;
  logic               unused_ir_s;

  assign ifid_op_s   = IF_ID_IR[6:0];
  assign ifid_rs1_s  = IF_ID_IR[19:15];
  assign ifid_rs2_s  = IF_ID_IR[24:20];
  assign idex_op_s   = ID_EX_IR[6:0];
  assign idex_rd_s   = ID_EX_IR[11:7];
  assign unused_ir_s = ^{IF_ID_IR[31:25], IF_ID_IR[14:7], ID_EX_IR[31:12]};

  assign mem_wait_s = dmem_req & ~dmem_ready;
  assign lu_haz_s   = (idex_op_s == OP_LOAD) && (idex_rd_s != 5'd0) &&
                      ((rs1_used(ifid_op_s) && (ifid_rs1_s == idex_rd_s)) ||
                       (rs2_used(ifid_op_s) && (ifid_rs2_s == idex_rd_s)));

  // Output decode and FSM next state; mem wait freezes everything and holds the FSM.
  always_comb begin
    state_d     = state_q;
    bub_cnt_d   = bub_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_wait_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      bub_cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (lu_haz_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d   = LU_STALL;
              bub_cnt_d = 2'd1;
            end else begin
              state_d   = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        LU_STALL: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          // This cycle inserts bubble bub_cnt_q+1; leave once the last is in.
          if (bub_cnt_q + 2'd1 == LU_LAST) begin
            state_d   = RUN;
            bub_cnt_d = 2'd0;
          end else begin
            bub_cnt_d = bub_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d   = RUN;
          bub_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Wait-cycle tracking, sticky timeout and saturating stall counter.
  always_comb begin
    wait_cnt_d    = 16'd0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    if (mem_wait_s) begin
      wait_cnt_d = (wait_cnt_q == TMO) ? wait_cnt_q : wait_cnt_q + 16'd1;
      if (wait_cnt_q + 16'd1 == TMO) begin
        mem_timeout_d = 1'b1;
      end else begin
        mem_timeout_d = mem_timeout_q;
      end
    end else begin
      wait_cnt_d = 16'd0;
    end
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      bub_cnt_q     <= 2'd0;
      wait_cnt_q    <= 16'd0;
      stall_cnt_q   <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bub_cnt_q     <= bub_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (LU_BUBBLES=2, MEM_TIMEOUT=4): the driver
// queues hand-computed expectations, the monitor pops and compares each cycle.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X5   = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] ADD_X0   = 32'h0020_0333; // add  x6,x0,x2
  localparam logic [31:0] LUI_R5   = 32'h0002_82B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] ADDI_R5  = 32'h0053_8313; // addi x6,x7,5 (rs2 field = 5)
  localparam logic [31:0] SW_X5    = 32'h0050_A023; // sw   x5,0(x1)

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_STL  = 5'b00111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [1:0] FL_NONE = 2'b00;
  localparam logic [1:0] FL_IDEX = 2'b01;
  localparam logic [1:0] FL_BOTH = 2'b11;

  typedef struct {
    int          id;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_id_ir = 32'h0;
  logic [31:0] id_ex_ir = 32'h0;
  logic        branch_taken = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_timeout;
  logic [31:0] stall_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  logic drain_fail = 1'b0;

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_IR(if_id_ir), .ID_EX_IR(id_ex_ir),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle presents a response at negedge.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] en_s;
    if (drain_fail) begin
      errors = errors + 1;
      $display("FAIL drain: queue still holds %0d entries, required 0", exp_q.size());
      drain_fail = 1'b0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      en_s = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
      checks = checks + 4;
      if (en_s !== e.en) begin
        errors = errors + 1;
        $display("FAIL step%0d enables: got %b required %b", e.id, en_s, e.en);
      end
      if ({if_id_flush, id_ex_flush} !== e.fl) begin
        errors = errors + 1;
        $display("FAIL step%0d flushes: got %b required %b", e.id, {if_id_flush, id_ex_flush}, e.fl);
      end
      if (stall_cnt !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL step%0d stall_cnt: got %0d required %0d", e.id, stall_cnt, e.cnt);
      end
      if (mem_timeout !== e.to) begin
        errors = errors + 1;
        $display("FAIL step%0d mem_timeout: got %b required %b", e.id, mem_timeout, e.to);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] ifid, input logic [31:0] idex,
                      input logic br, input logic req, input logic rdy,
                      input logic [4:0] en, input logic [1:0] fl,
                      input logic [31:0] cnt, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = r;
    if_id_ir     = ifid;
    id_ex_ir     = idex;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    step_id      = step_id + 1;
    e.id  = step_id;
    e.en  = en;
    e.fl  = fl;
    e.cnt = cnt;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset outputs regardless of a hazard on the inputs
    step(1'b0, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_NONE, FL_BOTH, 32'd0, 1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd0, 1'b0);
    // Load-use with two bubbles
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd0, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd1, 1'b0);
    step(1'b1, ADD_X5, NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd2, 1'b0);
    // False positives
    step(1'b1, ADD_X0, LW_X0, 1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd2, 1'b0);
    step(1'b1, LUI_R5, LW_X5, 1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd2, 1'b0);
    step(1'b1, ADDI_R5, LW_X5, 1'b0, 1'b0, 1'b0, EN_ALL, FL_NONE, 32'd2, 1'b0);
    // Store rs2 hazard, then a branch inside LU_STALL wins and returns to RUN
    step(1'b1, SW_X5,  LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd2, 1'b0);
    step(1'b1, SW_X5,  LW_X5, 1'b1, 1'b0, 1'b0, EN_ALL,  FL_BOTH, 32'd3, 1'b0);
    // Branch beats load-use in RUN
    step(1'b1, ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0, EN_ALL,  FL_BOTH, 32'd3, 1'b0);
    // Mem wait during LU_STALL pauses the bubble count
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd3, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd4, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd5, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd6, 1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b1, 1'b1, EN_STL,  FL_IDEX, 32'd7, 1'b0);
    step(1'b1, ADD_X5, NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd8, 1'b0);
    // Mem wait beats branch; the wait counter clears on a ready cycle
    step(1'b1, NOP,    NOP,   1'b1, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd8, 1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b1, EN_ALL,  FL_NONE, 32'd9, 1'b0);
    // Timeout after the 4th consecutive wait cycle, sticky afterwards
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd9,  1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd10, 1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd11, 1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b0, EN_NONE, FL_NONE, 32'd12, 1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b1, 1'b1, EN_ALL,  FL_NONE, 32'd13, 1'b1);
    step(1'b1, NOP,    NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd13, 1'b1);
    // Reset in the middle of LU_STALL: no bubble carry-over
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd13, 1'b1);
    step(1'b0, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_NONE, FL_BOTH, 32'd0,  1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd0,  1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd0,  1'b0);
    step(1'b1, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0, EN_STL,  FL_IDEX, 32'd1,  1'b0);
    step(1'b1, NOP,    NOP,   1'b0, 1'b0, 1'b0, EN_ALL,  FL_NONE, 32'd2,  1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) drain_fail = 1'b1;
    @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
